// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the aq_djpeg output path: pixel entry layout and TDATA packing.
package aq_djpeg_pkg;

    localparam int unsigned PIX_W   = 24;
    localparam int unsigned COORD_W = 16;

    // Bit offsets of each field inside a stored FIFO entry
    localparam int unsigned B_OFS   = 0;
    localparam int unsigned G_OFS   = 8;
    localparam int unsigned R_OFS   = 16;
    localparam int unsigned X_OFS   = 24;
    localparam int unsigned Y_OFS   = 40;
    localparam int unsigned SOF_OFS = 56;
    localparam int unsigned EOF_OFS = 57;
    localparam int unsigned ENTRY_W = 58;

    // Packed MSB-first, so field positions match the offsets above
    typedef struct packed {
        logic               eof;
        logic               sof;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
        logic [PIX_W-1:0]   rgb;
    } pix_entry_t;

    // The zero pad byte is inserted here rather than stored in the RAM
    function automatic logic [63:0] entry_to_tdata(input logic [ENTRY_W-1:0] e);
        return {e[Y_OFS +: COORD_W], e[X_OFS +: COORD_W], 8'd0,
                e[R_OFS +: 8], e[G_OFS +: 8], e[B_OFS +: 8]};
    endfunction

endpackage

// File: rtl/aq_axis_djpeg_outbuf_ram.sv
// Simple dual-port RAM for the output buffer: one write port, one registered read port.
module aq_axis_djpeg_outbuf_ram
    import aq_djpeg_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [ENTRY_W-1:0]    i_wr_data,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [ENTRY_W-1:0]    o_rd_data
);

    logic [ENTRY_W-1:0] r_mem [2**DEPTH_LOG2];

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; data holds while i_rd_en is low
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/aq_axis_djpeg_outbuf.sv
// Elastic FIFO between the decoder pixel outputs and an AXI4-Stream master with SOF/EOF flags.
module aq_axis_djpeg_outbuf
    import aq_djpeg_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = 9,
    parameter int unsigned AFULL_MARGIN = 16
) (
    input  logic                  i_aclk,
    input  logic                  i_aresetn,
    input  logic                  i_clear,
    input  logic                  i_pix_valid,
    input  logic [15:0]           i_pix_x,
    input  logic [15:0]           i_pix_y,
    input  logic [15:0]           i_pix_width,
    input  logic [15:0]           i_pix_height,
    input  logic [7:0]            i_pix_r,
    input  logic [7:0]            i_pix_g,
    input  logic [7:0]            i_pix_b,
    output logic                  o_dec_stall,
    output logic                  o_overflow,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic [15:0]           o_frame_cnt,
    output logic [63:0]           o_m_axis_tdata,
    output logic                  o_m_axis_tuser,
    output logic                  o_m_axis_tlast,
    output logic [7:0]            o_m_axis_tkeep,
    output logic                  o_m_axis_tvalid,
    input  logic                  i_m_axis_tready
);

    localparam int unsigned LW        = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AFULL = LW'(DEPTH - AFULL_MARGIN);

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_s1_vld;    // RAM read register holds a valid entry
    logic [LW-1:0]         w_level_next;
    logic [LW-1:0]         w_ram_cnt;
    logic                  w_wr;
    logic                  w_pop;
    logic                  w_rd_en;
    logic                  w_s1_adv;
    pix_entry_t            w_wr_entry;
    logic [ENTRY_W-1:0]    w_rd_data;

    assign o_level        = r_level;
    assign o_m_axis_tkeep = 8'hFF;

    // Entry flags, handshake and pipeline-advance decisions
    always_comb begin
        w_wr_entry.sof = (i_pix_x == 16'd0) && (i_pix_y == 16'd0);
        w_wr_entry.eof = (i_pix_width != 16'd0) && (i_pix_height != 16'd0) &&
                         (i_pix_x == i_pix_width - 16'd1) && (i_pix_y == i_pix_height - 16'd1);
        w_wr_entry.y   = i_pix_y;
        w_wr_entry.x   = i_pix_x;
        w_wr_entry.rgb = {i_pix_r, i_pix_g, i_pix_b};
        // Full is judged on registered level only, so a same-cycle pop does not make room
        w_wr      = i_pix_valid && !i_clear && (r_level != LVL_FULL);
        w_pop     = o_m_axis_tvalid && i_m_axis_tready;
        w_s1_adv  = r_s1_vld && (!o_m_axis_tvalid || w_pop);
        // Entries still sitting in RAM, not yet fetched into the read or output register
        w_ram_cnt = r_level - LW'(r_s1_vld) - LW'(o_m_axis_tvalid);
        w_rd_en   = !i_clear && (w_ram_cnt != '0) && (!r_s1_vld || w_s1_adv);
        w_level_next = i_clear ? '0 : (r_level + LW'(w_wr) - LW'(w_pop));
    end

    aq_axis_djpeg_outbuf_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk     (i_aclk),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Pointers, occupancy and status counters
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            o_dec_stall <= 1'b0;
            o_overflow  <= 1'b0;
            o_frame_cnt <= 16'd0;
        end else begin
            r_level     <= w_level_next;
            o_dec_stall <= (w_level_next >= LVL_AFULL);
            if (i_clear) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                o_overflow  <= 1'b0;
                o_frame_cnt <= 16'd0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
                end
                if (w_rd_en) begin
                    r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
                end
                if (i_pix_valid && !w_wr) begin
                    o_overflow <= 1'b1;
                end
                if (w_pop && o_m_axis_tlast) begin
                    o_frame_cnt <= o_frame_cnt + 16'd1;
                end
            end
        end
    end

    // Read-register valid and the AXIS output register
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_s1_vld        <= 1'b0;
            o_m_axis_tvalid <= 1'b0;
            o_m_axis_tdata  <= 64'd0;
            o_m_axis_tuser  <= 1'b0;
            o_m_axis_tlast  <= 1'b0;
        end else if (i_clear) begin
            r_s1_vld        <= 1'b0;
            o_m_axis_tvalid <= 1'b0;
            o_m_axis_tdata  <= 64'd0;
            o_m_axis_tuser  <= 1'b0;
            o_m_axis_tlast  <= 1'b0;
        end else begin
            r_s1_vld <= w_rd_en || (r_s1_vld && !w_s1_adv);
            if (w_s1_adv) begin
                o_m_axis_tvalid <= 1'b1;
                o_m_axis_tdata  <= entry_to_tdata(w_rd_data);
                o_m_axis_tuser  <= w_rd_data[SOF_OFS];
                o_m_axis_tlast  <= w_rd_data[EOF_OFS];
            end else if (w_pop) begin
                o_m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
